// File: rtl/rf_arb_pkg.sv
// Shared types and defaults for the register-file port arbiter.
package rf_arb_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned AW_DEF   = 5;

    // Debug access FSM states
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StForce = 2'd2,
        StResp  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rf_starve_counter.sv
// Saturating count of cycles a debug request has been refused a port.
module rf_starve_counter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] Limit = CW'(STARVE_LIMIT);

    logic [CW-1:0] count_q, count_d;

    // Next count: clear wins, otherwise saturate at the limit
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != Limit)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign hit = (count_q == Limit);

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the register-file write port and rs2 read port between the core and
// a debug access port. Core traffic has priority; a starving debug request
// gets one forced core-stall cycle in which it is always granted.
module regfile_port_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned XLEN         = XLEN_DEF,
    parameter int unsigned AW           = AW_DEF,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic [AW-1:0]   core_rs2_addr,
    input  logic            core_rs2_used,
    output logic [XLEN-1:0] core_rs2_data,
    output logic            core_stall,
    output logic            rf_we,
    output logic [AW-1:0]   rf_rd_addr,
    output logic [XLEN-1:0] rf_rd_data,
    output logic [AW-1:0]   rf_rs2_addr,
    input  logic [XLEN-1:0] rf_rs2_data,
    input  logic            dbg_req_valid,
    input  logic            dbg_req_we,
    input  logic [AW-1:0]   dbg_req_addr,
    input  logic [XLEN-1:0] dbg_req_wdata,
    output logic            dbg_req_ready,
    output logic            dbg_rsp_valid,
    output logic [XLEN-1:0] dbg_rsp_rdata
);

    arb_state_e state_q, state_d;

    logic            rsp_valid_q;
    logic [XLEN-1:0] rsp_rdata_q;
    logic [XLEN-1:0] rd_capture;
    logic            accept;
    logic            core_we;
    logic            port_free;
    logic            cnt_inc, cnt_clr, cnt_hit;

    rf_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .hit   (cnt_hit)
    );

    // Grant decision and register-file port muxing
    always_comb begin
        core_stall = (state_q == StForce);
        core_we    = wb_valid & ~core_stall;
        // A stalled core frees both ports
        port_free  = dbg_req_we ? (~wb_valid | core_stall) : (~core_rs2_used | core_stall);

        unique case (state_q)
            StIdle, StWait: dbg_req_ready = dbg_req_valid & port_free;
            StForce:        dbg_req_ready = 1'b1;
            default:        dbg_req_ready = 1'b0;
        endcase
        accept = dbg_req_valid & dbg_req_ready;

        rf_we       = core_we;
        rf_rd_addr  = wb_rd;
        rf_rd_data  = wb_data;
        rf_rs2_addr = core_rs2_addr;
        if (accept && dbg_req_we) begin
            rf_we      = (dbg_req_addr != '0);
            rf_rd_addr = dbg_req_addr;
            rf_rd_data = dbg_req_wdata;
        end else if (accept) begin
            rf_rs2_addr = dbg_req_addr;
        end
    end

    // Read data seen by the debug port; a same-cycle core write to the same
    // register is forwarded so the read observes it
    always_comb begin
        rd_capture = rf_rs2_data;
        if (dbg_req_we || (dbg_req_addr == '0)) begin
            rd_capture = '0;
        end else if (core_we && (wb_rd == dbg_req_addr)) begin
            rd_capture = wb_data;
        end
    end

    // FSM next state and starvation counter control
    always_comb begin
        state_d = state_q;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        unique case (state_q)
            StIdle, StWait: begin
                if (accept) begin
                    state_d = StResp;
                    cnt_clr = 1'b1;
                end else if (dbg_req_valid) begin
                    state_d = ((state_q == StWait) && cnt_hit) ? StForce : StWait;
                    cnt_inc = 1'b1;
                end else begin
                    state_d = StIdle;
                    cnt_clr = 1'b1;
                end
            end
            StForce: begin
                state_d = accept ? StResp : StIdle;
                cnt_clr = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered response with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= accept;
            if (accept) begin
                rsp_rdata_q <= rd_capture;
            end
        end
    end

    assign core_rs2_data = rf_rs2_data;
    assign dbg_rsp_valid = rsp_valid_q;
    assign dbg_rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter: a behavioural register file plus a
// response scoreboard checked every cycle.
module tb_regfile_port_arbiter;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int LIMIT = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            wb_valid;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [AW-1:0]   core_rs2_addr;
    logic            core_rs2_used;
    logic [XLEN-1:0] core_rs2_data;
    logic            core_stall;
    logic            rf_we;
    logic [AW-1:0]   rf_rd_addr;
    logic [XLEN-1:0] rf_rd_data;
    logic [AW-1:0]   rf_rs2_addr;
    logic [XLEN-1:0] rf_rs2_data;
    logic            dbg_req_valid;
    logic            dbg_req_we;
    logic [AW-1:0]   dbg_req_addr;
    logic [XLEN-1:0] dbg_req_wdata;
    logic            dbg_req_ready;
    logic            dbg_rsp_valid;
    logic [XLEN-1:0] dbg_rsp_rdata;

    typedef struct {
        logic [XLEN-1:0] data;
        int              cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [XLEN-1:0] rf_mem [32];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file: x0 hardwired, cleared by bench reset
    assign rf_rs2_data = rf_mem[rf_rs2_addr];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
        end else if (rf_we && rf_rd_addr != 0) begin
            rf_mem[rf_rd_addr] <= rf_rd_data;
        end
    end

    regfile_port_arbiter #(
        .XLEN         (XLEN),
        .AW           (AW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .core_rs2_addr (core_rs2_addr),
        .core_rs2_used (core_rs2_used),
        .core_rs2_data (core_rs2_data),
        .core_stall    (core_stall),
        .rf_we         (rf_we),
        .rf_rd_addr    (rf_rd_addr),
        .rf_rd_data    (rf_rd_data),
        .rf_rs2_addr   (rf_rs2_addr),
        .rf_rs2_data   (rf_rs2_data),
        .dbg_req_valid (dbg_req_valid),
        .dbg_req_we    (dbg_req_we),
        .dbg_req_addr  (dbg_req_addr),
        .dbg_req_wdata (dbg_req_wdata),
        .dbg_req_ready (dbg_req_ready),
        .dbg_rsp_valid (dbg_rsp_valid),
        .dbg_rsp_rdata (dbg_rsp_rdata)
    );

    task automatic idle_inputs();
        wb_valid      = 1'b0;
        wb_rd         = '0;
        wb_data       = '0;
        core_rs2_addr = 5'd1;
        core_rs2_used = 1'b0;
        dbg_req_valid = 1'b0;
        dbg_req_we    = 1'b0;
        dbg_req_addr  = '0;
        dbg_req_wdata = '0;
    endtask

    task automatic dbg_req(input logic we, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        dbg_req_valid = 1'b1;
        dbg_req_we    = we;
        dbg_req_addr  = a;
        dbg_req_wdata = d;
    endtask

    task automatic expect_rsp(input logic [XLEN-1:0] d);
        exp_t e;
        e.data = d;
        e.cyc  = cyc;
        exp_q.push_back(e);
    endtask

    // Wait for the sampling point of this cycle and check the response port
    task automatic sample();
        exp_t e;
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0 && exp_q[0].cyc + 1 == cyc) begin
            e = exp_q.pop_front();
            if (dbg_rsp_valid !== 1'b1 || dbg_rsp_rdata !== e.data) begin
                n_fail++;
                $display("FAIL rsp: got valid=%b rdata=%h, required valid=1 rdata=%h",
                         dbg_rsp_valid, dbg_rsp_rdata, e.data);
            end
        end else if (dbg_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rsp_unexpected: got valid=%b rdata=%h, required valid=0",
                     dbg_rsp_valid, dbg_rsp_rdata);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        advance();
        advance();
        @(negedge clk);
        n_checks++;
        if (core_stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %b, required 0", core_stall);
        end
        n_checks++;
        if (dbg_req_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b, required 0", dbg_req_ready);
        end
        n_checks++;
        if (dbg_rsp_valid !== 1'b0 || dbg_rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rsp: got valid=%b rdata=%h, required 0/0",
                     dbg_rsp_valid, dbg_rsp_rdata);
        end
        rst_n = 1'b1;
        advance();
    endtask

    task automatic test_write_read();
        dbg_req(1'b1, 5'd5, 32'hDEADBEEF);
        sample();
        n_checks++;
        if (dbg_req_ready !== 1'b1 || rf_we !== 1'b1 || rf_rd_addr !== 5'd5 ||
            rf_rd_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL wr_accept: got ready=%b we=%b addr=%0d data=%h, required 1/1/5/deadbeef",
                     dbg_req_ready, rf_we, rf_rd_addr, rf_rd_data);
        end
        expect_rsp(32'h0);
        advance();
        dbg_req_valid = 1'b0;
        sample();
        advance();
        dbg_req(1'b0, 5'd5, 32'h0);
        sample();
        n_checks++;
        if (dbg_req_ready !== 1'b1 || rf_rs2_addr !== 5'd5) begin
            n_fail++;
            $display("FAIL rd_accept: got ready=%b rs2_addr=%0d, required 1/5",
                     dbg_req_ready, rf_rs2_addr);
        end
        expect_rsp(32'hDEADBEEF);
        advance();
        dbg_req_valid = 1'b0;
        sample();
        advance();
    endtask

    task automatic test_back_to_back();
        logic            we_t [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [AW-1:0]   ad_t [4] = '{5'd10, 5'd11, 5'd10, 5'd11};
        logic [XLEN-1:0] wd_t [4] = '{32'h11, 32'h22, 32'h0, 32'h0};
        logic [XLEN-1:0] ex_t [4] = '{32'h0, 32'h0, 32'h11, 32'h22};
        dbg_req(we_t[0], ad_t[0], wd_t[0]);
        for (int i = 0; i < 4; i++) begin
            sample();
            n_checks++;
            if (dbg_req_ready !== 1'b1) begin
                n_fail++; $display("FAIL b2b_accept%0d: got %b, required 1", i, dbg_req_ready);
            end
            expect_rsp(ex_t[i]);
            advance();
            if (i < 3) dbg_req(we_t[i+1], ad_t[i+1], wd_t[i+1]);
            else dbg_req_valid = 1'b0;
            sample();
            n_checks++;
            if (dbg_req_ready !== 1'b0) begin
                n_fail++; $display("FAIL b2b_resp_ready%0d: got %b, required 0", i, dbg_req_ready);
            end
            advance();
        end
    endtask

    task automatic test_forced_stall();
        wb_valid = 1'b1;
        wb_rd    = 5'd3;
        wb_data  = 32'hAAAA;
        dbg_req(1'b1, 5'd9, 32'h55);
        for (int i = 0; i <= LIMIT; i++) begin
            sample();
            n_checks++;
            if (dbg_req_ready !== 1'b0 || core_stall !== 1'b0 || rf_rd_addr !== 5'd3) begin
                n_fail++;
                $display("FAIL starve_wait%0d: got ready=%b stall=%b rd_addr=%0d, required 0/0/3",
                         i, dbg_req_ready, core_stall, rf_rd_addr);
            end
            advance();
        end
        sample();
        n_checks++;
        if (core_stall !== 1'b1 || dbg_req_ready !== 1'b1 || rf_we !== 1'b1 ||
            rf_rd_addr !== 5'd9 || rf_rd_data !== 32'h55) begin
            n_fail++;
            $display("FAIL force_grant: got stall=%b ready=%b we=%b addr=%0d data=%h, required 1/1/1/9/55",
                     core_stall, dbg_req_ready, rf_we, rf_rd_addr, rf_rd_data);
        end
        expect_rsp(32'h0);
        advance();
        dbg_req_valid = 1'b0;
        sample();
        n_checks++;
        if (core_stall !== 1'b0 || rf_we !== 1'b1 || rf_rd_addr !== 5'd3) begin
            n_fail++;
            $display("FAIL force_release: got stall=%b we=%b addr=%0d, required 0/1/3",
                     core_stall, rf_we, rf_rd_addr);
        end
        advance();
        wb_valid = 1'b0;
        dbg_req(1'b0, 5'd9, 32'h0);
        sample();
        expect_rsp(32'h55);
        advance();
        dbg_req_valid = 1'b0;
        sample();
        advance();
    endtask

    task automatic test_forwarding();
        wb_valid      = 1'b1;
        wb_rd         = 5'd7;
        wb_data       = 32'h1234;
        core_rs2_used = 1'b0;
        dbg_req(1'b0, 5'd7, 32'h0);
        sample();
        n_checks++;
        if (dbg_req_ready !== 1'b1 || rf_rs2_addr !== 5'd7) begin
            n_fail++;
            $display("FAIL fwd_accept: got ready=%b rs2_addr=%0d, required 1/7",
                     dbg_req_ready, rf_rs2_addr);
        end
        expect_rsp(32'h1234);
        advance();
        // Core writes a different register: no forwarding, old x7 value wins
        wb_rd   = 5'd8;
        wb_data = 32'h9999;
        dbg_req_valid = 1'b0;
        sample();
        advance();
        dbg_req(1'b0, 5'd7, 32'h0);
        sample();
        expect_rsp(32'h1234);
        advance();
        wb_valid = 1'b0;
        dbg_req_valid = 1'b0;
        sample();
        advance();
    endtask

    task automatic test_x0();
        dbg_req(1'b1, 5'd0, 32'hFFFF);
        sample();
        n_checks++;
        if (dbg_req_ready !== 1'b1 || rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_write: got ready=%b we=%b, required 1/0", dbg_req_ready, rf_we);
        end
        expect_rsp(32'h0);
        advance();
        dbg_req_valid = 1'b0;
        sample();
        advance();
        // Core write to x0 in the same cycle must not be forwarded
        wb_valid = 1'b1;
        wb_rd    = 5'd0;
        wb_data  = 32'h77;
        dbg_req(1'b0, 5'd0, 32'h0);
        sample();
        expect_rsp(32'h0);
        advance();
        wb_valid = 1'b0;
        dbg_req_valid = 1'b0;
        sample();
        advance();
    endtask

    task automatic test_withdrawn();
        core_rs2_used = 1'b1;
        core_rs2_addr = 5'd2;
        dbg_req(1'b0, 5'd5, 32'h0);
        for (int i = 0; i < 3; i++) begin
            sample();
            n_checks++;
            if (dbg_req_ready !== 1'b0) begin
                n_fail++; $display("FAIL wd_blocked%0d: got %b, required 0", i, dbg_req_ready);
            end
            advance();
        end
        dbg_req_valid = 1'b0;
        sample();
        advance();
        dbg_req_valid = 1'b1;
        for (int i = 0; i <= LIMIT; i++) begin
            sample();
            n_checks++;
            if (dbg_req_ready !== 1'b0 || core_stall !== 1'b0) begin
                n_fail++;
                $display("FAIL wd_rewait%0d: got ready=%b stall=%b, required 0/0",
                         i, dbg_req_ready, core_stall);
            end
            advance();
        end
        sample();
        n_checks++;
        if (core_stall !== 1'b1 || dbg_req_ready !== 1'b1 || rf_rs2_addr !== 5'd5) begin
            n_fail++;
            $display("FAIL wd_force: got stall=%b ready=%b rs2_addr=%0d, required 1/1/5",
                     core_stall, dbg_req_ready, rf_rs2_addr);
        end
        expect_rsp(32'hDEADBEEF);
        advance();
        dbg_req_valid = 1'b0;
        core_rs2_used = 1'b0;
        sample();
        advance();
    endtask

    task automatic test_reset_mid();
        // Reset while in FORCE: transaction dropped
        wb_valid = 1'b1;
        wb_rd    = 5'd3;
        dbg_req(1'b1, 5'd12, 32'h66);
        for (int i = 0; i <= LIMIT; i++) begin
            sample();
            advance();
        end
        rst_n = 1'b0;
        sample();
        n_checks++;
        if (core_stall !== 1'b1) begin
            n_fail++; $display("FAIL rst_force_enter: got stall=%b, required 1", core_stall);
        end
        advance();
        rst_n = 1'b1;
        idle_inputs();
        sample();
        n_checks++;
        if (core_stall !== 1'b0 || dbg_req_ready !== 1'b0 || dbg_rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_force: got stall=%b ready=%b rdata=%h, required 0/0/0",
                     core_stall, dbg_req_ready, dbg_rsp_rdata);
        end
        advance();
        // Reset while in RESP after a read
        dbg_req(1'b1, 5'd13, 32'hABC);
        sample();
        expect_rsp(32'h0);
        advance();
        dbg_req_valid = 1'b0;
        sample();
        advance();
        dbg_req(1'b0, 5'd13, 32'h0);
        sample();
        n_checks++;
        if (dbg_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_resp_accept: got %b, required 1", dbg_req_ready);
        end
        expect_rsp(32'hABC);
        advance();
        dbg_req_valid = 1'b0;
        rst_n = 1'b0;
        sample();
        advance();
        rst_n = 1'b1;
        sample();
        n_checks++;
        if (dbg_rsp_rdata !== 32'h0 || core_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_resp: got rdata=%h stall=%b, required 0/0", dbg_rsp_rdata, core_stall);
        end
        advance();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_forced_stall();
        test_forwarding();
        test_x0();
        test_withdrawn();
        test_reset_mid();
        sample();
        advance();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
